uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver in the jacaranda-8 UART.
//  Adds runtime parity and stop-bit selection, 3-sample majority voting and false-start rejection.
//  Reports framing, parity and overrun errors and buffers frames in a FIFO with a valid/ready pop.
//  Sits between the rx pad and the CPU UART register file.
// PARAMETERS
//  DATA_W      8   data bits per frame; legal range 5..8
//  CNT_W       32  width of the clocks-per-bit count
//  FIFO_DEPTH  4   receive FIFO entries; power of two, >= 2
// PORTS
//  clk            in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  rx             in   1          asynchronous serial line; idles high
//  rx_en          in   1          1 = accept new start bits
//  clk_count_bit  in   CNT_W      clocks per bit (N); values below 4 are treated as 4
//  parity_mode    in   2          00 none, 01 even, 10 odd, 11 none
//  stop2          in   1          0 = 1 stop bit, 1 = 2 stop bits
//  rx_ready       in   1          consumer pops the head entry when rx_valid & rx_ready
//  rx_valid       out  1          FIFO not empty
//  rx_data        out  DATA_W     head entry data
//  rx_perr        out  1          head entry parity error
//  rx_ferr        out  1          head entry framing error
//  overrun        out  1          sticky: a frame was dropped because the FIFO was full
//  ovr_clr        in   1          clears overrun; a same-cycle drop wins and keeps it set
//  busy           out  1          state machine is not in IDLE
// BEHAVIOUR
//  - Reset (sync): FIFO emptied, state = IDLE, all counters = 0.
//    rx_valid = 0, rx_data = 0, rx_perr = 0, rx_ferr = 0, overrun = 0, busy = 0.
//    A reset mid-frame discards the partial frame.
//  - rx passes through a 2-FF synchroniser (reset value 1); "rxs" is the synchronised line.
//  - Bit timer counts 0..N-1 and wraps. Let H = N>>1.
//    rxs is sampled at counts H-1, H and H+1; the bit value is the 2-of-3 majority, decided at H+1.
//  - State machine:
//    IDLE:  if rx_en and rxs falls 1->0, clear the timer and go to START.
//    START: at the decision point, majority 1 = false start -> IDLE (no push); majority 0 -> DATA.
//    DATA:  shift in LSB first; after DATA_W bits go to PAR if parity is enabled, else STOP.
//    PAR:   check the sampled bit against the data parity; odd mode expects ^data == ~parity bit.
//    STOP:  majority 0 sets ferr. With stop2, the second stop bit is sampled as well.
//           ferr is the OR over both stop bits.
//    - The frame completes at the decision point of the last stop bit; this is the push cycle.
//    - Exit to WAIT_HI if the last stop bit sampled 0, else to IDLE.
//    WAIT_HI: stay until rxs = 1, then go to IDLE. This stops a break condition from retriggering.
//  - Changing rx_en mid-frame does not abort the frame; it only gates the IDLE -> START transition.
//  - parity_mode, stop2 and clk_count_bit are captured at the START entry and held for the frame.
//  - Push writes {perr, ferr, data}. Frames with errors are still pushed.
//  - Latency: rx_valid rises one cycle after the push cycle when the FIFO was empty.
//  - FIFO is show-ahead: head outputs are valid whenever rx_valid = 1.
//    Outputs are undefined-but-stable when empty; the RTL holds the last head value.
//  - Pop with rx_valid = 0 is ignored.
//  - Full FIFO with push and pop in the same cycle: both happen, no overrun.
//  - Full FIFO with push and no pop: the frame is dropped, overrun = 1, existing entries are untouched.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
// STRUCTURE
//  - Package uart_pkg: state encoding (IDLE, START, DATA, PAR, STOP, WAIT_HI),
//    parity_mode constants, and the clamp-to-4 helper.
//  - Sub-module rx_fifo (DATA_W+2 wide, FIFO_DEPTH deep, sync FIFO with push/pop/full/empty).
//  - Synchroniser, bit timer, majority vote and FSM stay in this module.
// TESTING (N = 16 unless noted)
//  1. 8N1, send 0xA5, rx_ready = 0 -> one entry: data A5, perr 0, ferr 0.
//     rx_valid rises at cycle 9.5*16+1+2 (sync) after the start edge.
//  2. Even parity, send 0x03 with parity bit 1 -> data 03, perr 1. Odd mode with parity bit 1 -> perr 0.
//  3. Stop bit held 0 for 20 bit times -> one entry with ferr 1; no further entries until rx returns high.
//  4. rx low pulse of 3 clocks while idle -> false start, no entry, busy back to 0 within N/2+2 cycles.
//  5. Depth 4, send 5 frames with no pop -> overrun 1 and entries 1..4 intact.
//     Then pop and push in the same cycle while full -> no overrun change.
//  6. Assert reset mid-DATA -> next cycle busy 0, rx_valid 0; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//  - rx_state_t     : receiver state encoding
//  - PAR_*          : parity_mode encodings
//  - clamp_clks_per_bit : forces the clocks-per-bit count to at least 4 so
//                     that the three majority samples (H-1, H, H+1) always
//                     fall inside one bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int unsigned MIN_CLKS_PER_BIT = 4;

  function automatic logic [63:0] clamp_clks_per_bit(input logic [63:0] n);
    return (n < 64'(MIN_CLKS_PER_BIT)) ? 64'(MIN_CLKS_PER_BIT) : n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Synchronous show-ahead FIFO for received frames.
// Ports:
//  clk, reset   system clock, synchronous active-high reset
//  push, wdata  write request and entry; ignored when full unless a pop
//               happens in the same cycle
//  pop          read request; ignored when empty
//  rdata        head entry; holds the last head value while empty
//  full, empty  status flags from the extra pointer MSB
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? hold_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      // Track the head so the output stays stable once the FIFO drains.
      if (!empty) hold_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime parity/stop selection, 3-sample majority
// voting, false-start rejection and a receive FIFO.
// Ports:
//  clk, reset      system clock, synchronous active-high reset
//  rx              asynchronous serial line (idles high)
//  rx_en           gates acceptance of new start bits
//  clk_count_bit   clocks per bit N (values below 4 act as 4)
//  parity_mode     00/11 none, 01 even, 10 odd
//  stop2           0 = one stop bit, 1 = two stop bits
//  rx_ready        consumer pops head when rx_valid & rx_ready
//  rx_valid        FIFO not empty
//  rx_data/rx_perr/rx_ferr  head entry
//  overrun         sticky dropped-frame flag, cleared by ovr_clr
//  busy            receiver state machine not idle
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rx_en,
  input  logic [CNT_W-1:0]  clk_count_bit,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              busy
);

  rx_state_t         state;
  logic              sync_ff, rxs, rxs_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  half;
  logic [1:0]        pmode_q;
  logic              stop2_q;
  logic              s0, s1;
  logic [DATA_W-1:0] shreg;
  logic [3:0]        bit_cnt;
  logic              stop_idx;
  logic              perr_q, ferr_q;
  logic              fall, start_det, dec, bit_val;
  logic              par_en, odd_mode, data_par;
  logic              push, fifo_full, fifo_empty;
  logic [DATA_W+1:0] wdata, rdata;

  // Synchroniser: two flops into rxs, one more for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      sync_ff <= rx;
      rxs     <= sync_ff;
      rxs_d   <= rxs;
    end
  end

  assign fall      = rxs_d && !rxs;
  assign start_det = (state == IDLE) && rx_en && fall;
  assign half      = n_q >> 1;
  // Decision point: third sample is the live rxs at count H+1.
  assign dec       = (cnt == half + CNT_W'(1));
  assign bit_val   = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign par_en    = (pmode_q != PAR_NONE) && (pmode_q != PAR_NONE_ALT);
  assign odd_mode  = (pmode_q == PAR_ODD);
  assign data_par  = ^shreg;

  // Frame configuration, majority samples and data shift register
  always_ff @(posedge clk) begin
    if (start_det) begin
      n_q     <= CNT_W'(clamp_clks_per_bit(64'(clk_count_bit)));
      pmode_q <= parity_mode;
      stop2_q <= stop2;
    end
    if (state != IDLE && cnt == half - CNT_W'(1)) s0 <= rxs;
    if (state != IDLE && cnt == half)             s1 <= rxs;
    if (state == DATA && dec) shreg <= {bit_val, shreg[DATA_W-1:1]};
  end

  // Receiver state machine and bit timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (state != IDLE) cnt <= (cnt == n_q - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (start_det) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (dec) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (dec) begin
            if (bit_cnt == 4'(DATA_W - 1)) state <= par_en ? PAR : STOP;
            else                          bit_cnt <= bit_cnt + 4'd1;
          end
        end
        PAR: begin
          if (dec) begin
            perr_q <= odd_mode ? (bit_val == data_par) : (bit_val != data_par);
            state  <= STOP;
          end
        end
        STOP: begin
          if (dec) begin
            ferr_q <= ferr_q | ~bit_val;
            if (stop_idx == stop2_q) begin
              // A low last stop bit may be a break; wait for the line to recover.
              state <= bit_val ? IDLE : WAIT_HI;
              busy  <= ~bit_val;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Frame completion: push at the last stop bit decision
  assign push  = (state == STOP) && dec && (stop_idx == stop2_q);
  assign wdata = {perr_q, ferr_q | ~bit_val, shreg};

  rx_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (rx_ready),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_perr  = rdata[DATA_W+1];
  assign rx_ferr  = rdata[DATA_W];
  assign rx_data  = rdata[DATA_W-1:0];

  // A drop needs full with no pop; a drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                              overrun <= 1'b0;
    else if (push && fifo_full && !rx_ready) overrun <= 1'b1;
    else if (ovr_clr)                       overrun <= 1'b0;
  end

endmodule
